dpram_port_arbiter: RTL and testbench

Round-robin arbiter that shares one port of the dual-port RAM between `NUM_REQ` requesters on a single clock domain. It serialises read/write commands onto the RAM port, one per cycle at most. It tracks in-flight reads through the RAM's fixed read latency and returns data to the issuing requester. It also stalls reads that would hit an address still being written within the RAM's write latency.

---
 rtl/dpram_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_dpram_port_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_port_arbiter.sv
// Round-robin arbiter sharing one RAM port among NUM_REQ requesters, with
// fixed-latency read-return routing and read-after-write hazard stalls.
module dpram_port_arbiter #(
    parameter int ADDR_WIDTH     = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int READ_LANTENCY  = 3,
    parameter int WRITE_LANTENCY = 3,
    parameter int NUM_REQ        = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [NUM_REQ-1:0]            i_req,
    input  logic [NUM_REQ-1:0]            i_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_din,
    output logic [NUM_REQ-1:0]            o_gnt,
    output logic [NUM_REQ-1:0]            o_rvalid,
    output logic [DATA_WIDTH-1:0]         o_rdata,
    output logic                          o_ram_en,
    output logic                          o_ram_we,
    output logic [ADDR_WIDTH-1:0]         o_ram_addr,
    output logic [DATA_WIDTH-1:0]         o_ram_din,
    input  logic [DATA_WIDTH-1:0]         i_ram_dout
);

    localparam int          IDX_W  = $clog2(NUM_REQ);
    localparam int unsigned NREQ_U = NUM_REQ;

    typedef logic [IDX_W-1:0] idx_t;

    function automatic idx_t f_wrap_add(input idx_t base, input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NREQ_U) s = s - NREQ_U;
        return idx_t'(s);
    endfunction

    logic [NUM_REQ-1:0]    r_gnt;
    idx_t                  r_gnt_idx;
    idx_t                  r_rr_ptr;
    logic                  r_ram_en;
    logic                  r_ram_we;
    logic [ADDR_WIDTH-1:0] r_ram_addr;
    logic [DATA_WIDTH-1:0] r_ram_din;
    logic [NUM_REQ-1:0]    r_rvalid;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic [READ_LANTENCY-1:0]  r_tag_vld;
    idx_t                      r_tag_idx [READ_LANTENCY];
    logic [WRITE_LANTENCY-1:0] r_wh_vld;
    logic [ADDR_WIDTH-1:0]     r_wh_addr [WRITE_LANTENCY];

    logic [NUM_REQ-1:0]    w_hazard;
    logic [NUM_REQ-1:0]    w_elig;
    logic                  w_found;
    idx_t                  w_win_idx;
    logic                  w_win_we;
    logic [ADDR_WIDTH-1:0] w_win_addr;
    logic [DATA_WIDTH-1:0] w_win_din;

    // Entry 0 of the write history mirrors the write now on the RAM port.
    always_comb begin
        w_hazard = '0;
        for (int unsigned k = 0; k < NREQ_U; k++) begin
            for (int unsigned j = 0; j < WRITE_LANTENCY; j++) begin
                if (r_wh_vld[j] && (r_wh_addr[j] == i_addr[k*ADDR_WIDTH +: ADDR_WIDTH]))
                    w_hazard[k] = 1'b1;
            end
        end
        w_elig = i_req & ~r_gnt & (i_we | ~w_hazard);
    end

    always_comb begin
        w_found   = 1'b0;
        w_win_idx = '0;
        for (int unsigned i = 0; i < NREQ_U; i++) begin
            if (!w_found && w_elig[f_wrap_add(r_rr_ptr, i)]) begin
                w_found   = 1'b1;
                w_win_idx = f_wrap_add(r_rr_ptr, i);
            end
        end
        w_win_we   = i_we[w_win_idx];
        w_win_addr = i_addr[32'(w_win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        w_win_din  = i_din[32'(w_win_idx)*DATA_WIDTH +: DATA_WIDTH];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_gnt      <= '0;
            r_gnt_idx  <= '0;
            r_rr_ptr   <= '0;
            r_ram_en   <= 1'b0;
            r_ram_we   <= 1'b0;
            r_ram_addr <= '0;
            r_ram_din  <= '0;
            r_rvalid   <= '0;
            r_rdata    <= '0;
            r_tag_vld  <= '0;
            r_tag_idx  <= '{default: '0};
            r_wh_vld   <= '0;
            r_wh_addr  <= '{default: '0};
        end else begin
            r_gnt    <= '0;
            r_ram_en <= w_found;
            r_ram_we <= w_found & w_win_we;
            if (w_found) begin
                r_gnt[w_win_idx] <= 1'b1;
                r_gnt_idx        <= w_win_idx;
                r_rr_ptr         <= f_wrap_add(w_win_idx, 1);
                r_ram_addr       <= w_win_addr;
                r_ram_din        <= w_win_din;
            end

            r_tag_vld[0] <= r_ram_en & ~r_ram_we;
            r_tag_idx[0] <= r_gnt_idx;
            for (int unsigned j = 1; j < READ_LANTENCY; j++) begin
                r_tag_vld[j] <= r_tag_vld[j-1];
                r_tag_idx[j] <= r_tag_idx[j-1];
            end

            r_wh_vld[0]  <= w_found & w_win_we;
            r_wh_addr[0] <= w_win_addr;
            for (int unsigned j = 1; j < WRITE_LANTENCY; j++) begin
                r_wh_vld[j]  <= r_wh_vld[j-1];
                r_wh_addr[j] <= r_wh_addr[j-1];
            end

            r_rvalid <= '0;
            if (r_tag_vld[READ_LANTENCY-1]) begin
                r_rvalid[r_tag_idx[READ_LANTENCY-1]] <= 1'b1;
                r_rdata                              <= i_ram_dout;
            end
        end
    end

    assign o_gnt      = r_gnt;
    assign o_rvalid   = r_rvalid;
    assign o_rdata    = r_rdata;
    assign o_ram_en   = r_ram_en;
    assign o_ram_we   = r_ram_we;
    assign o_ram_addr = r_ram_addr;
    assign o_ram_din  = r_ram_din;

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Self-checking bench for dpram_port_arbiter: directed vector table, hand-written
// corner sequences, and randomized traffic against a cycle-level reference model.
module tb_dpram_port_arbiter;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int RL = 3;
    localparam int WL = 3;
    localparam int NR = 4;

    logic               i_clk = 1'b0;
    logic               i_rst_n;
    logic [NR-1:0]      i_req;
    logic [NR-1:0]      i_we;
    logic [NR*AW-1:0]   i_addr;
    logic [NR*DW-1:0]   i_din;
    logic [NR-1:0]      o_gnt;
    logic [NR-1:0]      o_rvalid;
    logic [DW-1:0]      o_rdata;
    logic               o_ram_en;
    logic               o_ram_we;
    logic [AW-1:0]      o_ram_addr;
    logic [DW-1:0]      o_ram_din;
    logic [DW-1:0]      i_ram_dout;

    always #5 i_clk = ~i_clk;

    dpram_port_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LANTENCY(RL),
        .WRITE_LANTENCY(WL), .NUM_REQ(NR)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_we(i_we),
        .i_addr(i_addr), .i_din(i_din), .o_gnt(o_gnt), .o_rvalid(o_rvalid),
        .o_rdata(o_rdata), .o_ram_en(o_ram_en), .o_ram_we(o_ram_we),
        .o_ram_addr(o_ram_addr), .o_ram_din(o_ram_din), .i_ram_dout(i_ram_dout)
    );

    function automatic logic [DW-1:0] f_init(input int a);
        return DW'(a * 37 + 11);
    endfunction

    // RAM model: write lands at the command edge, read data valid RL cycles after command.
    logic          ram_ready = 1'b0;
    logic [DW-1:0] ram_mem [16];
    logic [DW-1:0] rd_pipe [RL];

    always @(posedge i_clk) begin
        if (!ram_ready) begin
            for (int a = 0; a < 16; a++) ram_mem[a] <= f_init(a);
        end else if (o_ram_en && o_ram_we) begin
            ram_mem[o_ram_addr] <= o_ram_din;
        end
        rd_pipe[0] <= ram_mem[o_ram_addr];
        for (int j = 1; j < RL; j++) rd_pipe[j] <= rd_pipe[j-1];
    end
    assign i_ram_dout = rd_pipe[RL-1];

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] refmem [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge i_clk);
    endtask

    task automatic set_req(input int k, input logic r, input logic w,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        i_req[k]           = r;
        i_we[k]            = w;
        i_addr[k*AW +: AW] = a;
        i_din[k*DW +: DW]  = d;
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({o_gnt, o_rvalid, o_rdata, o_ram_en, o_ram_we, o_ram_addr, o_ram_din});
    endfunction

    typedef struct {
        int            k;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
        logic [DW-1:0] exp;
    } txn_t;

    typedef struct {
        int            k;
        logic [DW-1:0] d;
        int            due;
    } ret_t;

    txn_t tv [9];

    initial begin
        int            m_gnt;
        int            m_ptr;
        int            nxt;
        int            last_wr [16];
        logic          c_we;
        logic [AW-1:0] c_addr;
        logic [DW-1:0] c_din;
        ret_t          rq [$];

        tv[0] = '{k: 1, we: 1'b1, addr: 4'h5, din: 8'hA5, exp: 8'h00};
        tv[1] = '{k: 1, we: 1'b0, addr: 4'h5, din: 8'h00, exp: 8'hA5};
        tv[2] = '{k: 0, we: 1'b1, addr: 4'h3, din: 8'h3C, exp: 8'h00};
        tv[3] = '{k: 2, we: 1'b1, addr: 4'hF, din: 8'h5A, exp: 8'h00};
        tv[4] = '{k: 3, we: 1'b0, addr: 4'hF, din: 8'h00, exp: 8'h5A};
        tv[5] = '{k: 0, we: 1'b0, addr: 4'h3, din: 8'h00, exp: 8'h3C};
        tv[6] = '{k: 3, we: 1'b1, addr: 4'h0, din: 8'hC3, exp: 8'h00};
        tv[7] = '{k: 2, we: 1'b0, addr: 4'h0, din: 8'h00, exp: 8'hC3};
        tv[8] = '{k: 1, we: 1'b0, addr: 4'h5, din: 8'h00, exp: 8'hA5};

        for (int a = 0; a < 16; a++) refmem[a] = f_init(a);
        i_rst_n = 1'b0;
        i_req   = '0;
        i_we    = '0;
        i_addr  = '0;
        i_din   = '0;

        // Reset and idle
        tick();
        tick();
        check("reset_outputs", all_outs(), 32'h0);
        ram_ready = 1'b1;
        i_rst_n   = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            check("idle_outputs", all_outs(), 32'h0);
        end

        // Isolated transactions from the vector table
        for (int t = 0; t < 9; t++) begin
            set_req(tv[t].k, 1'b1, tv[t].we, tv[t].addr, tv[t].din);
            tick();
            check("txn_gnt", 32'(o_gnt), 32'(1 << tv[t].k));
            check("txn_cmd", 32'({o_ram_en, o_ram_we, o_ram_addr}), 32'({1'b1, tv[t].we, tv[t].addr}));
            if (tv[t].we) begin
                check("txn_din", 32'(o_ram_din), 32'(tv[t].din));
                refmem[tv[t].addr] = tv[t].din;
            end
            i_req[tv[t].k] = 1'b0;
            for (int c = 1; c <= 4; c++) begin
                tick();
                if (c == 1) check("txn_en_drop", 32'(o_ram_en), 32'h0);
                if (c == 4 && !tv[t].we) begin
                    check("txn_rvalid", 32'(o_rvalid), 32'(1 << tv[t].k));
                    check("txn_rdata", 32'(o_rdata), 32'(tv[t].exp));
                end else begin
                    check("txn_rvalid_idle", 32'(o_rvalid), 32'h0);
                end
            end
        end

        // Read-after-write hazard: requester 2 stalls, requester 1 proceeds
        set_req(0, 1'b1, 1'b1, 4'h3, 8'h3C);
        tick();
        check("haz_wr_gnt", 32'(o_gnt), 32'h1);
        check("haz_wr_cmd", 32'({o_ram_we, o_ram_addr, o_ram_din}), 32'({1'b1, 4'h3, 8'h3C}));
        refmem[3] = 8'h3C;
        i_req[0]  = 1'b0;
        set_req(2, 1'b1, 1'b0, 4'h3, 8'h00);
        set_req(1, 1'b1, 1'b0, 4'h7, 8'h00);
        tick();
        check("haz_bypass_gnt", 32'({o_gnt, o_ram_we, o_ram_addr}), 32'({4'b0010, 1'b0, 4'h7}));
        i_req[1] = 1'b0;
        tick();
        check("haz_stall_c2", 32'(o_gnt), 32'h0);
        tick();
        check("haz_stall_c3", 32'(o_gnt), 32'h0);
        tick();
        check("haz_rd_gnt", 32'({o_gnt, o_ram_we, o_ram_addr}), 32'({4'b0100, 1'b0, 4'h3}));
        i_req[2] = 1'b0;
        tick();
        check("haz_r1_rvalid", 32'({o_rvalid, o_rdata}), 32'({4'b0010, refmem[7]}));
        tick();
        check("haz_gap_c6", 32'(o_rvalid), 32'h0);
        tick();
        check("haz_gap_c7", 32'(o_rvalid), 32'h0);
        tick();
        check("haz_r2_rvalid", 32'({o_rvalid, o_rdata}), 32'({4'b0100, 8'h3C}));

        // Single requester: grant every other cycle, then pointer wraps to 0
        set_req(3, 1'b1, 1'b0, 4'h1, 8'h00);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("single_gnt", 32'(o_gnt), (i % 2 == 0) ? 32'h8 : 32'h0);
        end
        i_req[3] = 1'b0;
        set_req(0, 1'b1, 1'b0, 4'h2, 8'h00);
        set_req(1, 1'b1, 1'b0, 4'h2, 8'h00);
        tick();
        check("wrap_gnt0", 32'(o_gnt), 32'h1);
        i_req[0] = 1'b0;
        tick();
        check("wrap_gnt1", 32'(o_gnt), 32'h2);
        i_req[1] = 1'b0;
        for (int c = 0; c < 6; c++) tick();

        // All requesters read continuously from reset, then reset mid-flight
        i_rst_n = 1'b0;
        for (int k = 0; k < NR; k++) set_req(k, 1'b1, 1'b0, AW'(8 + k), 8'h00);
        tick();
        tick();
        i_rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("rr_gnt", 32'({o_gnt, o_ram_en}), 32'({4'(1 << (i % 4)), 1'b1}));
            if (i >= 4) begin
                check("rr_rvalid", 32'(o_rvalid), 32'(1 << ((i - 4) % 4)));
                check("rr_rdata", 32'(o_rdata), 32'(refmem[8 + (i - 4) % 4]));
            end else begin
                check("rr_rvalid_idle", 32'(o_rvalid), 32'h0);
            end
        end
        i_rst_n = 1'b0;
        i_req   = '0;
        tick();
        check("midreset_outputs", all_outs(), 32'h0);
        i_rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            check("midreset_no_rvalid", 32'({o_rvalid, o_ram_en}), 32'h0);
        end
        set_req(1, 1'b1, 1'b0, 4'h9, 8'h00);
        set_req(3, 1'b1, 1'b0, 4'hA, 8'h00);
        tick();
        check("midreset_ptr0", 32'(o_gnt), 32'h2);
        i_req = '0;
        for (int c = 0; c < 6; c++) tick();

        // Randomized traffic against the reference model
        i_rst_n = 1'b0;
        i_req   = '0;
        tick();
        i_rst_n = 1'b1;
        m_gnt   = -1;
        m_ptr   = 0;
        c_we    = 1'b0;
        c_addr  = '0;
        c_din   = '0;
        for (int a = 0; a < 16; a++) last_wr[a] = -100;
        for (int n = 0; n < 500; n++) begin
            tick();
            if (m_gnt >= 0) begin
                check("rnd_gnt", 32'(o_gnt), 32'(1 << m_gnt));
                check("rnd_cmd", 32'({o_ram_en, o_ram_we, o_ram_addr}), 32'({1'b1, c_we, c_addr}));
                if (c_we) check("rnd_din", 32'(o_ram_din), 32'(c_din));
            end else begin
                check("rnd_idle", 32'({o_gnt, o_ram_en, o_ram_we}), 32'h0);
            end
            if (rq.size() > 0 && rq[0].due == n) begin
                check("rnd_rvalid", 32'(o_rvalid), 32'(1 << rq[0].k));
                check("rnd_rdata", 32'(o_rdata), 32'(rq[0].d));
                void'(rq.pop_front());
            end else begin
                check("rnd_rvalid_idle", 32'(o_rvalid), 32'h0);
            end
            check("rnd_onehot", 32'(($countones(o_gnt) > 1) || ($countones(o_rvalid) > 1)), 32'h0);

            if (m_gnt >= 0) begin
                if (c_we) begin
                    refmem[c_addr] = c_din;
                    last_wr[c_addr] = n;
                end else begin
                    rq.push_back('{k: m_gnt, d: refmem[c_addr], due: n + RL + 1});
                end
                i_req[m_gnt] = 1'b0;
            end
            for (int k = 0; k < NR; k++) begin
                if (!i_req[k] && $urandom_range(0, 2) != 0)
                    set_req(k, 1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 3)), DW'($urandom));
            end

            nxt = -1;
            for (int i = 0; i < NR; i++) begin
                int j;
                j = (m_ptr + i) % NR;
                if (nxt < 0 && i_req[j] && j != m_gnt &&
                    (i_we[j] || (n - last_wr[i_addr[j*AW +: AW]]) >= WL))
                    nxt = j;
            end
            if (nxt >= 0) begin
                c_we   = i_we[nxt];
                c_addr = i_addr[nxt*AW +: AW];
                c_din  = i_din[nxt*DW +: DW];
                m_ptr  = (nxt + 1) % NR;
            end
            m_gnt = nxt;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
